// File: rtl/hba_uart_tx.sv
// rtl/hba_uart_tx.sv - HBA bus slave UART transmitter with a 4-entry byte FIFO
//
// Bytes written to TXDATA are queued and sent on uart_txd as 8N1 frames,
// or 8E1 frames when HBA_UART_TX_PARITY_EN is defined.
//
// Ports:
//   hba_clk, hba_reset  clock and asynchronous active-high reset
//   hba_rnw             1 = read, 0 = write
//   hba_select          transfer in progress
//   hba_abus            {peripheral, register} address
//   hba_dbus            write data
//   hba_dbus_out        read data, zero unless acknowledging a read
//   hba_xferack_out     one-cycle transfer acknowledge
//   uart_tx_interrupt   level interrupt: intr_en & fifo empty & serializer idle
//   uart_txd            serial output, idle high
//
// Registers: 0 TXDATA (W push), 1 STATUS (R {overflow, busy, empty, full},
// clear-on-read overflow), 2 CTRL (R/W {intr_en, tx_en}).

module hba_uart_tx_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [4];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [2:0]       count;
  logic             push_ok;
  logic             pop_ok;

  // Full is judged on the current count, so a push at count==4 is dropped
  // even if a pop happens in the same cycle.
  assign full    = (count == 3'd4);
  assign empty   = (count == 3'd0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop_ok)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push_ok} - {2'b00, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

module hba_uart_tx #(
  parameter int CLK_FREQUENCY     = 50_000_000,
  parameter int BAUD              = 115_200,
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int PERIPH_ADDR       = 0
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset,
  input  logic                  hba_rnw,
  input  logic                  hba_select,
  input  logic [ADDR_WIDTH-1:0] hba_abus,
  input  logic [DBUS_WIDTH-1:0] hba_dbus,
  output logic [DBUS_WIDTH-1:0] hba_dbus_out,
  output logic                  hba_xferack_out,
  output logic                  uart_tx_interrupt,
  output logic                  uart_txd
);

  localparam int DIVISOR = CLK_FREQUENCY / BAUD;
  localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);
  localparam logic [PERIPH_ADDR_WIDTH-1:0] MY_PERIPH = PERIPH_ADDR_WIDTH'(PERIPH_ADDR);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_TXDATA = REG_ADDR_WIDTH'(0);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_STATUS = REG_ADDR_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_CTRL   = REG_ADDR_WIDTH'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef HBA_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } tx_state_t;

  // Bus handshake
  logic                      ack_q;
  logic                      ack_dly_q;
  logic                      addressed;
  logic                      start_xfer;
  logic                      wr_cycle;
  logic                      rd_cycle;
  logic [REG_ADDR_WIDTH-1:0] reg_sel;

  // Control / status
  logic tx_en_q;
  logic intr_en_q;
  logic overflow_q;
  logic busy;

  // FIFO
  logic       fifo_push;
  logic       fifo_pop;
  logic [7:0] fifo_rdata;
  logic       fifo_full;
  logic       fifo_empty;

  // Serializer
  tx_state_t  state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       txd_q, txd_d;
  logic       bit_end;
`ifdef HBA_UART_TX_PARITY_EN
  logic       parity_q;
`endif

  assign addressed = hba_select && (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == MY_PERIPH);
  // Ignore select during the ack cycle and the one after it, so a master that
  // is slow to drop select does not trigger a second transfer.
  assign start_xfer = addressed & ~ack_q & ~ack_dly_q;
  assign reg_sel    = hba_abus[REG_ADDR_WIDTH-1:0];
  assign wr_cycle   = ack_q & ~hba_rnw;
  assign rd_cycle   = ack_q & hba_rnw;

  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      ack_q     <= 1'b0;
      ack_dly_q <= 1'b0;
    end else begin
      ack_q     <= start_xfer;
      ack_dly_q <= ack_q;
    end
  end

  assign hba_xferack_out = ack_q;

  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      tx_en_q    <= 1'b0;
      intr_en_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_cycle && reg_sel == REG_CTRL) begin
        tx_en_q   <= hba_dbus[0];
        intr_en_q <= hba_dbus[1];
      end
      if (fifo_push && fifo_full) begin
        overflow_q <= 1'b1;
      end else if (rd_cycle && reg_sel == REG_STATUS) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Read data is driven only during the ack cycle; STATUS shows the value
  // before the overflow clear that takes effect at the end of this cycle.
  always_comb begin
    hba_dbus_out = '0;
    if (rd_cycle) begin
      case (reg_sel)
        REG_STATUS: hba_dbus_out[3:0] = {overflow_q, busy, fifo_empty, fifo_full};
        REG_CTRL:   hba_dbus_out[1:0] = {intr_en_q, tx_en_q};
        default:    hba_dbus_out = '0;
      endcase
    end
  end

  assign fifo_push = wr_cycle && (reg_sel == REG_TXDATA);

  hba_uart_tx_fifo #(
    .WIDTH (8)
  ) u_fifo (
    .clk   (hba_clk),
    .rst   (hba_reset),
    .push  (fifo_push),
    .wdata (hba_dbus[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_end = (bit_cnt_q == CNT_LAST);
  assign busy    = (state_q != S_IDLE);
  assign uart_tx_interrupt = intr_en_q & fifo_empty & ~busy;
  assign uart_txd = txd_q;

  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

`ifdef HBA_UART_TX_PARITY_EN
  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      parity_q <= 1'b0;
    end else if (fifo_pop) begin
      parity_q <= ^fifo_rdata;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_en_q && !fifo_empty) begin
          state_d   = S_START;
          fifo_pop  = 1'b1;
          shift_d   = fifo_rdata;
          bit_idx_d = 3'd0;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef HBA_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef HBA_UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_IDLE || bit_end) bit_cnt_d = '0;

    // The line is registered from the next state so it changes in the same
    // cycle the state does and cannot glitch.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef HBA_UART_TX_PARITY_EN
      S_PARITY: txd_d = parity_q;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_hba_uart_tx.sv
// tb/tb_hba_uart_tx.sv - scoreboard bench for hba_uart_tx

module tb_hba_uart_tx;

  localparam int D = 50_000_000 / 115_200;
`ifdef HBA_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        hba_clk = 1'b0;
  logic        hba_reset = 1'b1;
  logic        hba_rnw = 1'b1;
  logic        hba_select = 1'b0;
  logic [11:0] hba_abus = '0;
  logic [7:0]  hba_dbus = '0;
  logic [7:0]  hba_dbus_out;
  logic        hba_xferack_out;
  logic        uart_tx_interrupt;
  logic        uart_txd;

  hba_uart_tx dut (
    .hba_clk           (hba_clk),
    .hba_reset         (hba_reset),
    .hba_rnw           (hba_rnw),
    .hba_select        (hba_select),
    .hba_abus          (hba_abus),
    .hba_dbus          (hba_dbus),
    .hba_dbus_out      (hba_dbus_out),
    .hba_xferack_out   (hba_xferack_out),
    .uart_tx_interrupt (uart_tx_interrupt),
    .uart_txd          (uart_txd)
  );

  always #5 hba_clk = ~hba_clk;

  int unsigned cyc = 0;
  always @(posedge hba_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]  exp_rd[$];
  logic [7:0]  exp_bytes[$];
  logic [7:0]  model_fifo[$];
  bit          model_ovf;
  int unsigned rx_starts[$];
  int unsigned edge_q[$];
  int          rx_started = 0;
  int          rx_done = 0;
  int unsigned last_ack_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Read-data monitor: pops one expected value per acknowledged read.
  initial begin
    forever begin
      @(negedge hba_clk);
      if (hba_xferack_out === 1'b1 && hba_rnw === 1'b1) begin
        if (exp_rd.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected: got 0x%0h expected no read", hba_dbus_out);
        end else begin
          check("rd_data", hba_dbus_out, exp_rd.pop_front());
        end
      end
    end
  end

  // Line edge logger.
  initial begin
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge hba_clk);
      if (uart_txd !== prev) edge_q.push_back(cyc);
      prev = uart_txd;
    end
  end

  // Serial receiver: samples each bit in its middle and checks the frame
  // against the next expected byte.
  bit         rx_aborted;
  logic [7:0] rx_byte;
  logic       rx_startbit, rx_stopbit, rx_par;
  logic [7:0] rx_eb;

  task automatic rx_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge hba_clk);
      if (hba_reset) rx_aborted = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(negedge hba_clk);
      if (!hba_reset && uart_txd === 1'b0) begin
        rx_aborted = 1'b0;
        rx_starts.push_back(cyc);
        rx_started++;
        rx_wait(D / 2);
        rx_startbit = uart_txd;
        for (int i = 0; i < 8; i++) begin
          rx_wait(D);
          rx_byte[i] = uart_txd;
        end
        rx_par = 1'b0;
`ifdef HBA_UART_TX_PARITY_EN
        rx_wait(D);
        rx_par = uart_txd;
`endif
        rx_wait(D);
        rx_stopbit = uart_txd;
        if (!rx_aborted) begin
          check("rx_start_bit", rx_startbit, 1'b0);
          check("rx_stop_bit", rx_stopbit, 1'b1);
          if (exp_bytes.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_unexpected_frame: got 0x%0h expected no frame", rx_byte);
          end else begin
            rx_eb = exp_bytes.pop_front();
            check("rx_byte", rx_byte, rx_eb);
`ifdef HBA_UART_TX_PARITY_EN
            check("rx_parity", rx_par, $countones(rx_eb) % 2);
`endif
          end
          rx_done++;
        end
      end
    end
  end

  task automatic bus_xfer(input bit rnw, input logic [3:0] periph, input logic [7:0] rg,
                          input logic [7:0] wd, input bit expect_ack);
    int  waited;
    bit  got;
    @(negedge hba_clk);
    hba_select = 1'b1;
    hba_rnw    = rnw;
    hba_abus   = {periph, rg};
    hba_dbus   = wd;
    got = 1'b0;
    waited = 0;
    while (!got && waited < 4) begin
      @(negedge hba_clk);
      waited++;
      if (hba_xferack_out === 1'b1) got = 1'b1;
    end
    if (expect_ack) begin
      check("ack_latency", got ? waited : 99, 1);
      last_ack_cyc = cyc;
      @(negedge hba_clk);
      hba_select = 1'b0;
      check("ack_single_cycle", hba_xferack_out, 1'b0);
      check("dbus_out_idle", hba_dbus_out, 8'h00);
    end else begin
      check("no_ack_other_periph", got, 1'b0);
      hba_select = 1'b0;
    end
    hba_rnw  = 1'b1;
    hba_abus = '0;
    hba_dbus = '0;
  endtask

  task automatic bus_write(input logic [7:0] rg, input logic [7:0] wd);
    bus_xfer(1'b0, 4'd0, rg, wd, 1'b1);
  endtask

  task automatic bus_read(input logic [7:0] rg, input logic [7:0] exp);
    exp_rd.push_back(exp);
    bus_xfer(1'b1, 4'd0, rg, 8'h00, 1'b1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (rx_done < target && n < budget) begin
      @(negedge hba_clk);
      n++;
    end
    check("frames_received", rx_done, target);
    repeat (D) @(negedge hba_clk);
  endtask

  task automatic wait_started(input int target, input int budget);
    int n;
    n = 0;
    while (rx_started < target && n < budget) begin
      @(negedge hba_clk);
      n++;
    end
    check("frame_started", rx_started, target);
  endtask

  task automatic wait_until_cyc(input int unsigned t);
    while (cyc < t) @(negedge hba_clk);
  endtask

  initial begin
    int unsigned s;
    int          base;
    int          n;
    int          lows;
    logic [7:0]  b;

    // Reset state
    repeat (3) @(negedge hba_clk);
    check("reset_txd", uart_txd, 1'b1);
    check("reset_ack", hba_xferack_out, 1'b0);
    check("reset_dbus_out", hba_dbus_out, 8'h00);
    check("reset_intr", uart_tx_interrupt, 1'b0);
    hba_reset = 1'b0;
    model_ovf = 1'b0;
    bus_read(8'd1, 8'h02);
    bus_read(8'd2, 8'h00);
    check("idle_txd", uart_txd, 1'b1);
    check("idle_intr", uart_tx_interrupt, 1'b0);

    // Single 0x55 frame: latency and bit widths
    bus_write(8'd2, 8'h01);
    edge_q.delete();
    exp_bytes.push_back(8'h55);
    bus_write(8'd0, 8'h55);
    wait_started(1, 10);
    check("start_after_ack", rx_starts[0] - last_ack_cyc, 2);
    wait_done(1, NB * D + 50);
    check("edge_count_0x55", edge_q.size(), 10);
    if (edge_q.size() == 10) begin
      for (int k = 1; k <= 8; k++) check("bit_edge_0x55", edge_q[k] - edge_q[0], k * D);
      check("stop_edge_0x55", edge_q[9] - edge_q[0], (NB - 1) * D);
    end

    // Overflow with tx disabled, then drain back-to-back
    bus_write(8'd2, 8'h00);
    for (int i = 0; i < 5; i++) begin
      b = 8'h11 + 8'(i);
      if (model_fifo.size() < 4) model_fifo.push_back(b);
      else model_ovf = 1'b1;
      bus_write(8'd0, b);
    end
    bus_read(8'd1, {4'b0, model_ovf, 1'b0, model_fifo.size() == 0, model_fifo.size() == 4});
    model_ovf = 1'b0;
    bus_read(8'd1, {4'b0, model_ovf, 1'b0, model_fifo.size() == 0, model_fifo.size() == 4});
    base = rx_starts.size();
    while (model_fifo.size() > 0) exp_bytes.push_back(model_fifo.pop_front());
    bus_write(8'd2, 8'h01);
    wait_done(rx_done + 4, 4 * (NB * D + 1) + 100);
    for (int k = 1; k < 4; k++)
      check("frame_spacing", rx_starts[base + k] - rx_starts[base + k - 1], NB * D + 1);

    // Interrupt
    bus_write(8'd2, 8'h03);
    check("intr_idle_enabled", uart_tx_interrupt, 1'b1);
    exp_bytes.push_back(8'hA5);
    n = rx_started;
    bus_write(8'd0, 8'hA5);
    check("intr_low_after_push", uart_tx_interrupt, 1'b0);
    wait_started(n + 1, 10);
    s = rx_starts[$];
    wait_until_cyc(s + D * 5);
    check("intr_low_busy", uart_tx_interrupt, 1'b0);
    wait_until_cyc(s + NB * D - 1);
    check("intr_low_last_stop", uart_tx_interrupt, 1'b0);
    @(negedge hba_clk);
    check("intr_rise_after_stop", uart_tx_interrupt, 1'b1);
    bus_write(8'd2, 8'h01);
    check("intr_cleared", uart_tx_interrupt, 1'b0);
    wait_done(rx_done, 10);

    // Random traffic, register decode and foreign peripheral
    for (int r = 0; r < 2; r++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_bytes.push_back(b);
        bus_write(8'd0, b);
      end
      bus_read(8'd1, {5'b0, 1'b1, n == 1, 1'b0});
      b = 8'($urandom_range(3, 255));
      bus_write(b, 8'($urandom));
      bus_read(b, 8'h00);
      bus_read(8'd0, 8'h00);
      bus_write(8'd1, 8'hFF);
      bus_read(8'd2, 8'h01);
      bus_xfer(1'b0, 4'($urandom_range(1, 15)), 8'd2, 8'h00, 1'b0);
      wait_done(rx_done + n, n * (NB * D + 1) + 100);
    end

`ifdef HBA_UART_TX_PARITY_EN
    base = rx_starts.size();
    exp_bytes.push_back(8'h07);
    exp_bytes.push_back(8'h03);
    bus_write(8'd0, 8'h07);
    bus_write(8'd0, 8'h03);
    wait_done(rx_done + 2, 2 * (NB * D + 1) + 100);
    check("parity_frame_spacing", rx_starts[base + 1] - rx_starts[base], 11 * D + 1);
`endif

    // Reset during data bit 3 of 0xFF
    n = rx_started;
    exp_bytes.push_back(8'hFF);
    exp_bytes.push_back(8'h33);
    bus_write(8'd0, 8'hFF);
    bus_write(8'd0, 8'h33);
    wait_started(n + 1, 10);
    s = rx_starts[$];
    wait_until_cyc(s + 4 * D + D / 2);
    #2;
    hba_reset = 1'b1;
    exp_bytes.delete();
    #1;
    check("txd_async_reset", uart_txd, 1'b1);
    check("intr_async_reset", uart_tx_interrupt, 1'b0);
    repeat (3) @(negedge hba_clk);
    hba_reset = 1'b0;
    n = rx_done;
    bus_read(8'd1, 8'h02);
    bus_write(8'd2, 8'h01);
    lows = 0;
    for (int i = 0; i < NB * D + 20; i++) begin
      @(negedge hba_clk);
      if (uart_txd !== 1'b1) lows++;
    end
    check("no_frame_after_reset", lows, 0);
    check("no_rx_after_reset", rx_done, n);

    check("exp_rd_drained", exp_rd.size(), 0);
    check("exp_bytes_drained", exp_bytes.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hba_uart_tx.md
# hba_uart_tx

HBA bus slave peripheral that serializes bytes written by the bus master onto an asynchronous 8N1 serial line (optionally 8E1). It is the transmit-side counterpart of the serial receive path in serial_fpga and is used to send data from the FPGA to a host. Internally it is a 4-entry byte FIFO in front of a baud-rate bit serializer. It sits on the shared HBA bus next to other slaves such as hba_gpio.

## Interface
- CLK_FREQUENCY, 50_000_000, hba_clk frequency in Hz
- BAUD, 115_200, line rate; DIVISOR = CLK_FREQUENCY/BAUD, truncated (434 at defaults)
- DBUS_WIDTH, 8, HBA data bus width
- PERIPH_ADDR_WIDTH, 4, peripheral-select field width
- REG_ADDR_WIDTH, 8, register field width
- ADDR_WIDTH, PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH, HBA address width
- PERIPH_ADDR, 0, this slave's peripheral number
- hba_clk  in  1  single clock for the whole block
- hba_reset  in  1  asynchronous, active-high reset
- hba_rnw  in  1  1=read, 0=write
- hba_select  in  1  transfer in progress
- hba_abus  in  ADDR_WIDTH  {periph, reg} address
- hba_dbus  in  DBUS_WIDTH  write data
- hba_dbus_out  out  DBUS_WIDTH  read data; 0 when not acknowledging a read
- hba_xferack_out  out  1  transfer acknowledge; 0 when inactive
- uart_tx_interrupt  out  1  level interrupt
- uart_txd  out  1  serial output, idle high

## Operation
- Addressed when hba_select=1 and hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH]==PERIPH_ADDR.
- Registers (reg field): 0 TXDATA (W: push byte; R: 0); 1 STATUS (R: bit0 full, bit1 empty, bit2 busy, bit3 overflow; W ignored); 2 CTRL (R/W: bit0 tx_en, bit1 intr_en). Other reg addresses: writes ignored, reads return 0, still acknowledged.
- TXDATA write with FIFO full: byte dropped, overflow bit set (sticky). Full is evaluated before any same-cycle pop; a push at count==4 is always rejected.
- STATUS read returns the pre-clear value, then clears overflow.
- Serializer FSM: IDLE -> START -> DATA(8 bits, LSB first) -> [PARITY] -> STOP -> IDLE. Each state/bit lasts DIVISOR cycles, timed by a bit counter of $clog2(DIVISOR) bits reset at each bit boundary.
- IDLE -> START when tx_en=1 and FIFO non-empty; the head byte is popped into the shift register on that transition.
- Clearing tx_en mid-frame: the current frame completes; no further bytes are loaded. FIFO contents are retained.
- busy = FSM not in IDLE. uart_tx_interrupt = intr_en & empty & ~busy.
- FIFO count is 0..4. Read and write pointers are 2 bits and wrap modulo 4.

## Timing
- Reset values: uart_txd=1, hba_xferack_out=0, hba_dbus_out=0, uart_tx_interrupt=0, FIFO empty, overflow=0, CTRL=0, FSM IDLE.
- Reset asserted mid-frame: uart_txd goes to 1 immediately (asynchronously) and the FIFO is flushed.
- Handshake: hba_xferack_out pulses high for exactly one cycle, in the cycle after an addressed hba_select is first seen. On a read, hba_dbus_out is valid only in that cycle.
- While hba_xferack_out=1, or in the cycle following it, a still-asserted hba_select does not start a new transfer. The master drops select after the ack.
- Writes commit on the ack cycle. A TXDATA write to an empty, idle, enabled block drives uart_txd low 2 cycles after the ack.
- There is exactly one IDLE cycle between consecutive frames. Frame length is 10·DIVISOR cycles (11·DIVISOR with parity) plus 1.

## Configuration
- HBA_UART_TX_PARITY_EN defined: a PARITY state is inserted after DATA, transmitting the even-parity bit (XOR of the 8 data bits) for DIVISOR cycles.
- HBA_UART_TX_PARITY_EN undefined: the PARITY state and its logic are absent; frames are 8N1.

## Test plan
- Reset, then read STATUS -> ack after 1 cycle, data 0x02. uart_txd=1. Interrupt 0.
- Write CTRL=0x01, then TXDATA=0x55 -> line shows start, bits 1,0,1,0,1,0,1,0, stop, each 434 cycles; the low edge comes 2 cycles after the ack.
- With tx_en=0, write 5 bytes (0x11..0x15) -> STATUS=0x09. A second STATUS read returns 0x01. Set tx_en -> exactly 0x11..0x14 are sent, back-to-back with a 1-cycle gap.
- Set CTRL=0x03, write 0xA5 -> interrupt 0 while busy, rises 1 cycle after the stop bit ends. Clearing intr_en drops it.
- Assert hba_reset during data bit 3 of 0xFF -> uart_txd=1 at once, STATUS reads 0x02 after release, no further frame is sent.
- Parity build, send 0x07 -> parity bit 1. Send 0x03 -> parity bit 0. Frame is 11·434 cycles.
